edge_threshold: RTL
===================

# edge_threshold

Post-convolution stage that sits directly downstream of the 3×3 edge convolution and consumes its packed 30-bit signed-channel stream. It converts each pixel to an edge magnitude, compares it against a per-frame-latched threshold, forces a border band to zero, and emits a displayable edge image. It also reports a per-frame count of edge pixels to software/LEDs.

## Interface
- `W`, 30: pixel word width, three 10-bit channels at [29:20] R, [19:10] G, [9:0] B.
- `WIDTH`, 320: pixels per line.
- `HEIGHT`, 240: lines per frame.
- `BORDER`, 1: width in pixels of the forced-zero frame border; legal range 0..4.

Ports:
- `clk`  in  1  single clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `x`  dstream.in  W (+valid, ready)  convolution output stream; channels are 10-bit two's complement.
- `y`  dstream.out  W (+valid, ready)  edge image stream.
- `threshold`  in  11  unsigned magnitude threshold, sampled per frame.
- `edge_count`  out  17  edge pixels in last completed frame.
- `frame_done`  out  1  one-cycle pulse when `edge_count` updates.

## Operation
- Position counters `col` (0..WIDTH-1) and `row` (0..HEIGHT-1) advance on every accepted input (`x.valid & x.ready`). `col` wraps to 0 and increments `row`. `row` wraps to 0 after HEIGHT-1.
- Threshold latch: `thr_q <= threshold` on the accepted beat with col=0, row=0. That beat and all of its frame use the new value. Changes mid-frame have no effect until the next frame.
- Stage 1 (on accept):
  - Per channel: `mag = |ch|`, saturated to 511 (−512 → 511).
  - `sum = magR + magG + magB`, 11 bits unsigned, max 1533.
  - `border = col<BORDER | col>=WIDTH-BORDER | row<BORDER | row>=HEIGHT-BORDER`.
  - `last = (col==WIDTH-1 & row==HEIGHT-1)`.
  - `sum`, `border`, `last` are registered.
- Stage 2:
  - `edge = (sum > thr_q) & ~border`. Strictly greater: sum == thr_q is not an edge.
  - `y.data = edge ? 30'h3FFFFFFF : 0`.
- Edge counter:
  - Running count `run` (17 bits) increments when stage 2 loads an edge pixel.
  - When stage 2 loads a `last` pixel: `edge_count <= run + edge`, `run <= 0`, `frame_done` pulses for 1 cycle.
  - Max count 76800 fits in 17 bits; no saturation needed.
- State: the frame tracker has two states.
  - `IDLE`: after reset, no beat yet accepted.
  - `ACTIVE`: entered on the first accepted beat. It returns to IDLE only on reset.
  - `frame_done` never fires in IDLE.

## Timing
- Two-stage pipeline; latency is 2 cycles from accept to `y.valid` when `y.ready` stays high.
- Global enable `en = y.ready | ~y.valid`. Both stages and the stage valids advance only on `en`.
- `x.ready = en` (combinational). Throughput is 1 pixel/cycle.
- Backpressure: while `y.valid & ~y.ready`, `y.data`/`y.valid` hold stable, stage 1 holds, and no input is accepted.
- `y.valid` drops when a bubble (`x.valid=0`) reaches stage 2.
- Reset (async, any cycle including mid-frame):
  - `y.valid=0`, `y.data=0`, `edge_count=0`, `frame_done=0`.
  - `col=row=0`, `run=0`, `thr_q=0`, state IDLE.
  - In-flight pixels are discarded. The next accepted beat is treated as col 0, row 0.
- Simultaneous last-pixel load and edge: the edge is included in `edge_count`, and `run` restarts at 0, not 1.
- BORDER=0: no pixels are forced to zero.

## Configuration
- `EDGE_THRESHOLD_GRAY_EN` defined:
  - Edge pixels output `{g,g,g}`, with `g = min(sum,1023)` in each 10-bit channel.
  - Non-edge pixels are 0.
  - Counting is unchanged.
- Undefined: binary output (all-ones / zero) as above.

## Test plan
- Reset, then stream 76800 beats of 30'h0 with `y.ready=1` → `y.valid` first asserts 2 cycles after first accept; all outputs 0; `frame_done` pulses once; `edge_count=0`.
- threshold=100, interior pixel R=G=B=10'h3CE (−50) → sum=150 → `y.data=30'h3FFFFFFF`. Same pixel at col 0 → 0. Sum exactly 100 → 0.
- Channel value 10'h200 (−512) on R only, threshold=510 → mag 511 > 510 → edge. With `EDGE_THRESHOLD_GRAY_EN`, `y.data = {10'd511,10'd511,10'd511}`.
- Full frame of constant 10'h064 per channel (sum=300), threshold=0, BORDER=1 → `edge_count = 318*238 = 75684`. Change threshold to 400 mid-frame → count unchanged; the next frame gives 0.
- Hold `y.ready=0` for 5 cycles mid-stream → `x.ready=0`, and `y.data`/`y.valid` are stable throughout. After release, the pixel order and count are intact with no duplicates or drops.
- Assert `reset` at pixel 1000 of a frame, then stream a full frame → exactly one `frame_done`, after 76800 post-reset beats, with the correct count.

Source files
------------

// File: rtl/edge_threshold_if.sv
// Valid/ready pixel stream between the edge convolution, edge_threshold and the display path.
// The producer drives data/valid through the master modport and the consumer drives ready.
interface edge_threshold_if #(
  parameter int W = 30
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/edge_threshold.sv
// Edge magnitude thresholding with a border mask and a per-frame edge-pixel count.
// Define EDGE_THRESHOLD_GRAY_EN to output a grayscale magnitude on edge pixels instead of all-ones.
module edge_threshold #(
  parameter int W      = 30,
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int BORDER = 1
) (
  input  logic               clk,
  input  logic               reset,
  edge_threshold_if.slave    x,
  edge_threshold_if.master   y,
  input  logic [10:0]        threshold,
  output logic [16:0]        edge_count,
  output logic               frame_done
);

  // Counter widths leave room for WIDTH/HEIGHT themselves so BORDER=0 never wraps the upper bound.
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] COL_LO   = CW'(BORDER);
  localparam logic [CW-1:0] COL_HI   = CW'(WIDTH - BORDER);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_LO   = RW'(BORDER);
  localparam logic [RW-1:0] ROW_HI   = RW'(HEIGHT - BORDER);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [10:0]    thr_q;

  logic           s1_valid_q;
  logic [10:0]    s1_sum_q, sum_d;
  logic           s1_border_q, border_d;
  logic           s1_last_q, last_d;

  logic           y_valid_q;
  logic [W-1:0]   y_data_q, y_data_d;
  logic [16:0]    run_q;
  logic [16:0]    edge_count_q;
  logic           done_q;

  logic           en;
  logic           accept;
  logic           first_px;
  logic           edge_hit;
  logic           load2;

  function automatic logic [8:0] ch_mag(input logic [9:0] ch);
    logic [9:0] neg;
    neg = 10'd0 - ch;
    if (ch == 10'h200) return 9'd511;
    else if (ch[9])    return neg[8:0];
    else               return ch[8:0];
  endfunction

  // One enable moves the whole pipeline, so a stalled output freezes both stages and the input.
  assign en      = y.ready | ~y_valid_q;
  assign x.ready = en;
  assign accept  = x.valid & en;
  assign load2   = en & s1_valid_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    col_d = col_q + 1'b1;
    row_d = row_q;
    if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end
  end

  always_comb begin
    sum_d    = {2'b00, ch_mag(x.data[29:20])}
             + {2'b00, ch_mag(x.data[19:10])}
             + {2'b00, ch_mag(x.data[9:0])};
    border_d = (col_q < COL_LO) | (col_q >= COL_HI) | (row_q < ROW_LO) | (row_q >= ROW_HI);
    last_d   = (col_q == COL_LAST) & (row_q == ROW_LAST);
    first_px = (col_q == '0) & (row_q == '0);
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      thr_q <= '0;
    end else if (accept) begin
      col_q <= col_d;
      row_q <= row_d;
      if (first_px) thr_q <= threshold;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_border_q <= 1'b0;
      s1_last_q   <= 1'b0;
    end else if (en) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_sum_q    <= sum_d;
        s1_border_q <= border_d;
        s1_last_q   <= last_d;
      end
    end
  end

  // thr_q already holds the new frame's value when that frame's first pixel reaches this compare.
  assign edge_hit = (s1_sum_q > thr_q) & ~s1_border_q;

`ifdef EDGE_THRESHOLD_GRAY_EN
  logic [9:0] gray;
  always_comb begin
    gray     = s1_sum_q[10] ? 10'd1023 : s1_sum_q[9:0];
    y_data_d = '0;
    if (s1_valid_q && edge_hit) y_data_d = W'({gray, gray, gray});
  end
`else
  always_comb begin
    y_data_d = '0;
    if (s1_valid_q && edge_hit) y_data_d = '1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
    end else if (en) begin
      y_valid_q <= s1_valid_q;
      y_data_q  <= y_data_d;
    end
  end

  // The last pixel's own edge is folded into the published count while run restarts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q        <= '0;
      edge_count_q <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= load2 & s1_last_q;
      if (load2) begin
        if (s1_last_q) begin
          edge_count_q <= run_q + 17'(edge_hit);
          run_q        <= '0;
        end else if (edge_hit) begin
          run_q <= run_q + 17'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && accept) state_d = ACTIVE;
  end

  always_comb begin
    frame_done = done_q & (state_q == ACTIVE);
  end

  assign y.valid    = y_valid_q;
  assign y.data     = y_data_q;
  assign edge_count = edge_count_q;

endmodule
